present_ctrl_sched: RTL and testbench

- Avalon-MM slave that sequences an iterative PRESENT-80 round datapath.
- Holds plaintext and key registers, launches one encryption per START command, and steps the datapath through ROUNDS round cycles.
- Captures the ciphertext and raises a sticky "avail" flag that software polls.
- Sits between the system interconnect and the present round datapath, beside the existing avail PIO.

---
 rtl/present_pkg.sv | 34 +++
 rtl/present_ctrl_fsm.sv | 68 ++++++
 rtl/present_ctrl_sched.sv | 149 ++++++++++++++
 tb/tb_present_ctrl_sched.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// Shared constants and types for the PRESENT-80 control scheduler.
// Register map, CTRL/STATUS bit positions and the sequencer state encoding.
package present_pkg;

    localparam int PRESENT_BLK_W = 64;
    localparam int PRESENT_KEY_W = 80;

    localparam logic [3:0] ADDR_PT_LO  = 4'd0;
    localparam logic [3:0] ADDR_PT_HI  = 4'd1;
    localparam logic [3:0] ADDR_KEY_LO = 4'd2;
    localparam logic [3:0] ADDR_KEY_MI = 4'd3;
    localparam logic [3:0] ADDR_KEY_HI = 4'd4;
    localparam logic [3:0] ADDR_CTRL   = 4'd5;
    localparam logic [3:0] ADDR_STATUS = 4'd6;
    localparam logic [3:0] ADDR_CT_LO  = 4'd7;
    localparam logic [3:0] ADDR_CT_HI  = 4'd8;

    localparam int CTRL_START_BIT     = 0;
    localparam int CTRL_CLR_AVAIL_BIT = 1;
    localparam int CTRL_IRQ_ENA_BIT   = 2;

    localparam int STATUS_AVAIL_BIT   = 0;
    localparam int STATUS_BUSY_BIT    = 1;
    localparam int STATUS_WR_ERR_BIT  = 2;
    localparam int STATUS_IRQ_ENA_BIT = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_ROUND   = 2'd2,
        ST_CAPTURE = 2'd3
    } state_e;

endpackage

// File: rtl/present_ctrl_fsm.sv
// Round sequencer: IDLE -> LOAD -> ROUND x ROUNDS -> CAPTURE -> IDLE.
// Owns the round counter and derives dp_load / dp_round_en / busy from state.
module present_ctrl_fsm
    import present_pkg::*;
#(
    parameter int ROUNDS = 31,
    parameter int CNT_W  = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    output logic             load_o,
    output logic             round_en_o,
    output logic [CNT_W-1:0] round_cnt_o,
    output logic             busy_o,
    output state_e           state_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_LOAD;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_LOAD:  state_d = ST_ROUND;
            ST_ROUND: begin
                // Counter holds at ROUNDS on the exit edge so it never wraps.
                if (cnt_q == CNT_W'(ROUNDS)) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign load_o      = (state_q == ST_LOAD);
    assign round_en_o  = (state_q == ST_ROUND);
    assign round_cnt_o = round_en_o ? cnt_q : '0;
    assign busy_o      = (state_q != ST_IDLE);
    assign state_o     = state_q;

endmodule

// File: rtl/present_ctrl_sched.sv
// Avalon-MM register front end that launches and sequences PRESENT-80 blocks.
// Define PRESENT_CTRL_SCHED_IRQ_EN to add the irq output and CTRL IRQ_ENA bit.
module present_ctrl_sched
    import present_pkg::*;
#(
    parameter int ROUNDS = 31,
    parameter int CNT_W  = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [3:0]               address,
    input  logic                     chipselect,
    input  logic                     write_n,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    output logic                     dp_load,
    output logic                     dp_round_en,
    output logic [CNT_W-1:0]         dp_round_cnt,
    output logic [PRESENT_BLK_W-1:0] dp_pt,
    output logic [PRESENT_KEY_W-1:0] dp_key,
    input  logic [PRESENT_BLK_W-1:0] dp_ct,
    output logic                     busy
`ifdef PRESENT_CTRL_SCHED_IRQ_EN
    ,
    output logic                     irq
`endif
);

    // Slave has no waitrequest: a write completes on the edge where
    // chipselect && !write_n is seen; reads are combinational on address.
    logic wr_en, ctrl_wr, start, clr_avail, data_wr, capture;
    state_e fsm_state;

    logic [PRESENT_BLK_W-1:0] pt_q, pt_d, ct_q, ct_d;
    logic [PRESENT_KEY_W-1:0] key_q, key_d;
    logic                     avail_q, avail_d, wr_err_q, wr_err_d;

    assign wr_en     = chipselect && !write_n;
    assign ctrl_wr   = wr_en && (address == ADDR_CTRL);
    assign start     = ctrl_wr && writedata[CTRL_START_BIT];
    assign clr_avail = ctrl_wr && writedata[CTRL_CLR_AVAIL_BIT];
    assign data_wr   = wr_en && (address <= ADDR_KEY_HI);
    assign capture   = (fsm_state == ST_CAPTURE);

    present_ctrl_fsm #(
        .ROUNDS (ROUNDS),
        .CNT_W  (CNT_W)
    ) u_fsm (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .start_i     (start),
        .load_o      (dp_load),
        .round_en_o  (dp_round_en),
        .round_cnt_o (dp_round_cnt),
        .busy_o      (busy),
        .state_o     (fsm_state)
    );

    always_comb begin
        pt_d     = pt_q;
        key_d    = key_q;
        ct_d     = ct_q;
        avail_d  = avail_q;
        wr_err_d = wr_err_q;
        if (data_wr && !busy) begin
            case (address)
                ADDR_PT_LO:  pt_d[31:0]   = writedata;
                ADDR_PT_HI:  pt_d[63:32]  = writedata;
                ADDR_KEY_LO: key_d[31:0]  = writedata;
                ADDR_KEY_MI: key_d[63:32] = writedata;
                ADDR_KEY_HI: key_d[79:64] = writedata[15:0];
                default: ;
            endcase
        end
        // Capture is last so a coincident CLR_AVAIL loses to the new result.
        if ((start && !busy) || clr_avail) avail_d = 1'b0;
        if (capture) begin
            ct_d    = dp_ct;
            avail_d = 1'b1;
        end
        if (wr_en && (address == ADDR_STATUS) && writedata[STATUS_WR_ERR_BIT]) wr_err_d = 1'b0;
        if (data_wr && busy) wr_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pt_q     <= '0;
            key_q    <= '0;
            ct_q     <= '0;
            avail_q  <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            pt_q     <= pt_d;
            key_q    <= key_d;
            ct_q     <= ct_d;
            avail_q  <= avail_d;
            wr_err_q <= wr_err_d;
        end
    end

    logic irq_ena_rd;
`ifdef PRESENT_CTRL_SCHED_IRQ_EN
    logic irq_ena_q, irq_ena_d, irq_q, irq_d;

    always_comb begin
        irq_ena_d = ctrl_wr ? writedata[CTRL_IRQ_ENA_BIT] : irq_ena_q;
        irq_d     = avail_q && irq_ena_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_ena_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            irq_ena_q <= irq_ena_d;
            irq_q     <= irq_d;
        end
    end

    assign irq        = irq_q;
    assign irq_ena_rd = irq_ena_q;
`else
    assign irq_ena_rd = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_PT_LO:  readdata = pt_q[31:0];
            ADDR_PT_HI:  readdata = pt_q[63:32];
            ADDR_KEY_LO: readdata = key_q[31:0];
            ADDR_KEY_MI: readdata = key_q[63:32];
            ADDR_KEY_HI: readdata = {16'h0000, key_q[79:64]};
            ADDR_STATUS: begin
                readdata[STATUS_AVAIL_BIT]   = avail_q;
                readdata[STATUS_BUSY_BIT]    = busy;
                readdata[STATUS_WR_ERR_BIT]  = wr_err_q;
                readdata[STATUS_IRQ_ENA_BIT] = irq_ena_rd;
            end
            ADDR_CT_LO:  readdata = ct_q[31:0];
            ADDR_CT_HI:  readdata = ct_q[63:32];
            default:     readdata = '0;
        endcase
    end

    assign dp_pt  = pt_q;
    assign dp_key = key_q;

endmodule

// File: tb/tb_present_ctrl_sched.sv
// Bench for present_ctrl_sched with a behavioural PRESENT-80 round datapath
// and a ciphertext scoreboard fed from published test vectors.
module tb_present_ctrl_sched;

    localparam logic [3:0] A_PT_LO  = 4'd0;
    localparam logic [3:0] A_PT_HI  = 4'd1;
    localparam logic [3:0] A_KEY_LO = 4'd2;
    localparam logic [3:0] A_KEY_MI = 4'd3;
    localparam logic [3:0] A_KEY_HI = 4'd4;
    localparam logic [3:0] A_CTRL   = 4'd5;
    localparam logic [3:0] A_STATUS = 4'd6;
    localparam logic [3:0] A_CT_LO  = 4'd7;
    localparam logic [3:0] A_CT_HI  = 4'd8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        dp_load;
    logic        dp_round_en;
    logic [4:0]  dp_round_cnt;
    logic [63:0] dp_pt;
    logic [79:0] dp_key;
    logic [63:0] dp_ct;
    logic        busy;
`ifdef PRESENT_CTRL_SCHED_IRQ_EN
    logic        irq;
`endif

    present_ctrl_sched dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .dp_load      (dp_load),
        .dp_round_en  (dp_round_en),
        .dp_round_cnt (dp_round_cnt),
        .dp_pt        (dp_pt),
        .dp_key       (dp_key),
        .dp_ct        (dp_ct),
        .busy         (busy)
`ifdef PRESENT_CTRL_SCHED_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish before 400us");
        $fatal(1, "watchdog expired");
    end

    // ---------------- behavioural PRESENT-80 datapath ----------------
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'h21748FE3DA09B65C;
        return tbl[4*x +: 4];
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] s);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = sbox(s[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] p_layer(input logic [63:0] s);
        logic [63:0] r;
        for (int i = 0; i < 63; i++) r[(16*i) % 63] = s[i];
        r[63] = s[63];
        return r;
    endfunction

    function automatic logic [79:0] key_upd(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] r;
        r = {k[18:0], k[79:19]};
        r[79:76] = sbox(r[79:76]);
        r[19:15] = r[19:15] ^ rc;
        return r;
    endfunction

    logic [63:0] m_st;
    logic [79:0] m_key;
    always @(posedge clk) begin
        if (dp_load) begin
            m_st  <= dp_pt;
            m_key <= dp_key;
        end else if (dp_round_en) begin
            m_st  <= p_layer(s_layer(m_st ^ m_key[79:16]));
            m_key <= key_upd(m_key, dp_round_cnt);
        end
    end
    assign dp_ct = m_st ^ m_key[79:16];

    int en_total = 0;
    always @(posedge clk) if (dp_round_en === 1'b1) en_total <= en_total + 1;

    // ---------------- scoreboard / checking ----------------
    logic [63:0] exp_q[$];
    int tests  = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic load_regs(input logic [63:0] pt, input logic [79:0] key);
        bus_write(A_PT_LO,  pt[31:0]);
        bus_write(A_PT_HI,  pt[63:32]);
        bus_write(A_KEY_LO, key[31:0]);
        bus_write(A_KEY_MI, key[63:32]);
        bus_write(A_KEY_HI, {16'hFFFF, key[79:64]});
    endtask

    // Edges counted from the return of the START write; -1 means no avail seen.
    task automatic poll_avail(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            address = A_STATUS;
            #1;
            if (readdata[0] === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_ct(input string tag);
        logic [31:0] lo, hi;
        logic [63:0] e;
        bus_read(A_CT_LO, lo);
        bus_read(A_CT_HI, hi);
        check({tag, "_qsize"}, 64'(exp_q.size()), 64'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        check(tag, {hi, lo}, e);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] d;
        int          n, base;
        bit          found;

        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",     64'(busy), 64'd0);
        check("rst_cnt",      64'(dp_round_cnt), 64'd0);
        check("rst_load_en",  64'({dp_load, dp_round_en}), 64'd0);
        check("rst_pt_key",   64'(dp_pt | dp_key[63:0] | 64'(dp_key[79:64])), 64'd0);
        bus_read(A_STATUS, d); check("rst_status", 64'(d), 64'd0);
        bus_read(A_CT_LO,  d); check("rst_ct_lo",  64'(d), 64'd0);
        @(negedge clk) reset_n = 1'b1;

        // Block 1: all-zero vector, latency and round-enable count
        load_regs(64'h0, 80'h0);
        exp_q.push_back(64'h5579C1387B228445);
        base = en_total;
        bus_write(A_CTRL, 32'h1);
        poll_avail(n);
        check("lat_zero", 64'(n), 64'd33);
        check("en_cnt_zero", 64'(en_total - base), 64'd31);
        check_ct("ct_zero");

        // Block 2: key all ones; KEY_HI upper bits ignored
        load_regs(64'h0, 80'hFFFF_FFFFFFFF_FFFFFFFF);
        bus_read(A_KEY_HI, d); check("key_hi_mask", 64'(d), 64'h0000FFFF);
        exp_q.push_back(64'hE72C46C0F5945049);
        bus_write(A_CTRL, 32'h1);
        poll_avail(n);
        check("lat_keyf", 64'(n), 64'd33);
        check_ct("ct_keyf");

        // Block 3: plaintext all ones
        load_regs(64'hFFFFFFFF_FFFFFFFF, 80'h0);
        exp_q.push_back(64'hA112FFC72F68417B);
        bus_write(A_CTRL, 32'h1);
        poll_avail(n);
        check("lat_ptf", 64'(n), 64'd33);
        check_ct("ct_ptf");

        // Block 4: writes and START while busy are dropped
        load_regs(64'hFFFFFFFF_FFFFFFFF, 80'hFFFF_FFFFFFFF_FFFFFFFF);
        exp_q.push_back(64'h3333DCD3213210D2);
        base = en_total;
        bus_write(A_CTRL, 32'h1);
        bus_write(A_PT_LO, 32'hDEADBEEF);
        bus_write(A_CTRL, 32'h1);
        bus_read(A_STATUS, d); check("busy_wr_err", 64'(d[2:0]), 64'b110);
        bus_read(A_CT_LO, d);  check("ct_hold", 64'(d), 64'h2F68417B);
        poll_avail(n);
        check("avail_seen_busywr", 64'(n > 0), 64'd1);
        check_ct("ct_allf");
        bus_read(A_PT_LO, d);  check("pt_unchanged", 64'(d), 64'hFFFFFFFF);
        repeat (40) @(posedge clk);
        #1;
        check("one_block_only", 64'(en_total - base), 64'd31);
        check("idle_after", 64'(busy), 64'd0);
        bus_write(A_STATUS, 32'h4);
        bus_read(A_STATUS, d); check("wr_err_clr", 64'(d), 64'h1);

        // Block 5: CLR_AVAIL landing on the CAPTURE edge
        exp_q.push_back(64'h3333DCD3213210D2);
        bus_write(A_CTRL, 32'h1);
        repeat (32) @(posedge clk);
        #1;
        address = A_STATUS;
        #1;
        check("pre_capture", 64'(readdata[1:0]), 64'b10);
        bus_write(A_CTRL, 32'h2);
        bus_read(A_STATUS, d); check("clr_vs_set", 64'(d[1:0]), 64'b01);
        check_ct("ct_clr_edge");

        // Block 6: START|CLR_AVAIL in one write from IDLE
        exp_q.push_back(64'h3333DCD3213210D2);
        bus_write(A_CTRL, 32'h3);
        bus_read(A_STATUS, d); check("start_clr", 64'(d[1:0]), 64'b10);
        poll_avail(n);
        check("lat_start_clr", 64'(n), 64'd33);
        check_ct("ct_start_clr");

        // Reset during round 10, then a fresh block
        bus_write(A_CTRL, 32'h1);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (dp_round_cnt == 5'd10) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_round10", 64'(found), 64'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_cnt", 64'(dp_round_cnt), 64'd0);
        check("midrst_pt", dp_pt, 64'd0);
        bus_read(A_STATUS, d); check("midrst_status", 64'(d), 64'd0);
        @(negedge clk) reset_n = 1'b1;
        load_regs(64'hFFFFFFFF_FFFFFFFF, 80'h0);
        exp_q.push_back(64'hA112FFC72F68417B);
        base = en_total;
        bus_write(A_CTRL, 32'h1);
        poll_avail(n);
        check("lat_after_rst", 64'(n), 64'd33);
        check("en_cnt_after_rst", 64'(en_total - base), 64'd31);
        check_ct("ct_after_rst");

`ifdef PRESENT_CTRL_SCHED_IRQ_EN
        bus_write(A_CTRL, 32'h4);
        bus_read(A_STATUS, d); check("irq_ena_rd", 64'(d[3]), 64'd1);
        exp_q.push_back(64'hA112FFC72F68417B);
        bus_write(A_CTRL, 32'h5);
        poll_avail(n);
        check("irq_lag", 64'(irq), 64'd0);
        @(posedge clk); #1;
        check("irq_rise", 64'(irq), 64'd1);
        bus_write(A_CTRL, 32'h6);
        check("irq_hold", 64'(irq), 64'd1);
        @(posedge clk); #1;
        check("irq_fall", 64'(irq), 64'd0);
        check_ct("ct_irq");
        exp_q.push_back(64'hA112FFC72F68417B);
        bus_write(A_CTRL, 32'h1);
        poll_avail(n);
        repeat (2) @(posedge clk);
        #1;
        check("irq_disabled", 64'(irq), 64'd0);
        check_ct("ct_noirq");
`else
        bus_write(A_CTRL, 32'h4);
        bus_read(A_STATUS, d); check("irq_ena_absent", 64'(d[3]), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
